// File: rtl/spi_buf_pkg.sv
// spi_ring_buffer shared types and default parameter values.
// Imported by the ring buffer top.
package spi_buf_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_DEPTH    = 32768;
  localparam int DEF_SPI_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_DATA,
    RD_OUT
  } state_e;

endpackage

// File: rtl/spi_word_capture.sv
// Arms on spi_count==0, latches the SPI word on the last bit count.
// Holds one pending word; a second capture while pending is dropped.
module spi_word_capture #(
  parameter int DATA_W   = spi_buf_pkg::DEF_DATA_W,
  parameter int SPI_BITS = spi_buf_pkg::DEF_SPI_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        spi_count,
  input  logic [DATA_W-1:0] spi_word_in,
  input  logic              clr_pend,
  input  logic              flush,
  output logic [DATA_W-1:0] hold_word,
  output logic              pending,
  output logic              drop
);

  logic              armed_q, armed_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hit, busy, take;

  always_comb begin
    hit  = armed_q && (spi_count == 8'(SPI_BITS - 1));
    // the word being written this cycle frees the hold register
    busy = pend_q && !clr_pend;
    take = hit && !busy && !flush;
    drop = hit && busy && !flush;

    armed_d = armed_q;
    if (hit) begin
      armed_d = 1'b0;
    end else if (spi_count == 8'd0) begin
      armed_d = 1'b1;
    end

    hold_d = take ? spi_word_in : hold_q;

    pend_d = pend_q;
    if (flush || clr_pend) begin
      pend_d = 1'b0;
    end
    if (take) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b1;
      pend_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      armed_q <= armed_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
    end
  end

  assign hold_word = hold_q;
  assign pending   = pend_q;

endmodule

// File: rtl/spi_ring_buffer.sv
// SPI-fed ring buffer over an external single-port synchronous RAM.
// Define RING_OVERWRITE_EN to overwrite the oldest word when full.
module spi_ring_buffer #(
  parameter int DATA_W   = spi_buf_pkg::DEF_DATA_W,
  parameter int DEPTH    = spi_buf_pkg::DEF_DEPTH,
  parameter int SPI_BITS = spi_buf_pkg::DEF_SPI_BITS,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        spi_count,
  input  logic [DATA_W-1:0] spi_word_in,
  input  logic              rd_req,
  input  logic              flush,
  input  logic              clr_ovf,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  import spi_buf_pkg::*;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [DATA_W-1:0] hold_word;
  logic              pending, drop, clr_pend, ovf_set;

  spi_word_capture #(
    .DATA_W   (DATA_W),
    .SPI_BITS (SPI_BITS)
  ) u_cap (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_count   (spi_count),
    .spi_word_in (spi_word_in),
    .clr_pend    (clr_pend),
    .flush       (flush),
    .hold_word   (hold_word),
    .pending     (pending),
    .drop        (drop)
  );

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    rd_valid  = 1'b0;
    clr_pend  = 1'b0;
    ovf_set   = drop;

    unique case (state_q)
      IDLE: begin
        if (pending) begin
          state_d = WR;
        end else if (rd_req && !empty) begin
          state_d = RD;
        end
      end
      WR: begin
        clr_pend  = 1'b1;
        state_d   = IDLE;
        ram_addr  = wr_ptr_q;
        ram_wdata = hold_word;
        if (!full) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = count_q + CNT_ONE;
        end else begin
          ovf_set = 1'b1;
`ifdef RING_OVERWRITE_EN
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
`endif
        end
      end
      RD: begin
        ram_addr = rd_ptr_q;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - CNT_ONE;
        state_d  = RD_DATA;
      end
      RD_DATA: begin
        rd_data_d = ram_rdata;
        state_d   = RD_OUT;
      end
      RD_OUT: begin
        rd_valid = !flush;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // a set event in the same cycle beats clr_ovf
    ovf_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_data  = rd_data_q;

endmodule
